// File: rtl/lfsr_prn_gen.sv
// Fibonacci-style LFSR pseudo-random generator with a free-running tap mode
// and a handshaked serial word mode; zero seeds and lock-up states recover to SEED.
module lfsr_prn_gen #(
  parameter int unsigned      WIDTH  = 10,
  parameter logic [WIDTH-1:0] TAPS   = 10'h300,
  parameter int unsigned      OUT_W  = 5,
  parameter int unsigned      STRIDE = 2,
  parameter logic [WIDTH-1:0] SEED   = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             req,
  input  logic             prn_ready,
  output logic [OUT_W-1:0] prn,
  output logic             prn_valid,
  output logic             period_pulse,
  output logic             seed_err
);

  if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
    $error("lfsr_prn_gen: WIDTH must be within 3..32");
  end
  if (OUT_W < 1 || WIDTH < 1 + STRIDE * (OUT_W - 1)) begin : g_bad_taps
    $error("lfsr_prn_gen: WIDTH too small for OUT_W taps at STRIDE spacing");
  end
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_prn_gen: SEED must be nonzero");
  end

  localparam int unsigned CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           fsm_q, fsm_d;
  logic [WIDTH-1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] word_q, word_d;
  logic [OUT_W-1:0] prn_q, prn_d;
  logic             prn_valid_q, prn_valid_d;
  logic             period_q, period_d;
  logic             seed_err_q, seed_err_d;

  logic [WIDTH-1:0] shifted;
  logic [OUT_W-1:0] free_tap;

  assign shifted = {state_q[WIDTH-2:0], ^(state_q & TAPS)};

  // Free-run taps are taken from the post-shift state, MSB-anchored.
  for (genvar k = 0; k < OUT_W; k++) begin : g_tap
    assign free_tap[k] = shifted[WIDTH-1-STRIDE*k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      state_q     <= SEED;
      cnt_q       <= '0;
      word_q      <= '0;
      prn_q       <= '0;
      prn_valid_q <= 1'b0;
      period_q    <= 1'b0;
      seed_err_q  <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      prn_q       <= prn_d;
      prn_valid_q <= prn_valid_d;
      period_q    <= period_d;
      seed_err_q  <= seed_err_d;
    end
  end

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    prn_d       = prn_q;
    prn_valid_d = prn_valid_q;
    period_d    = 1'b0;
    seed_err_d  = 1'b0;

    if (seed_load) begin
      fsm_d       = IDLE;
      cnt_d       = '0;
      word_d      = '0;
      prn_valid_d = 1'b0;
      if (seed_in == '0) begin
        state_d    = SEED;
        seed_err_d = 1'b1;
      end else begin
        state_d = seed_in;
      end
    end else if (en) begin
      if (state_q == '0) begin
        // Lock-up recovery: abandon any word and restart from SEED.
        state_d     = SEED;
        seed_err_d  = 1'b1;
        fsm_d       = IDLE;
        cnt_d       = '0;
        prn_valid_d = 1'b0;
      end else begin
        unique case (fsm_q)
          IDLE: begin
            if (!mode) begin
              state_d     = shifted;
              prn_d       = free_tap;
              prn_valid_d = 1'b1;
              period_d    = (shifted == SEED);
            end else begin
              prn_valid_d = 1'b0;
              if (req) begin
                fsm_d  = SHIFT;
                cnt_d  = '0;
                word_d = '0;
              end
            end
          end
          SHIFT: begin
            word_d[cnt_q] = state_q[WIDTH-1];
            state_d       = shifted;
            period_d      = (shifted == SEED);
            if (cnt_q == CNT_W'(OUT_W - 1)) begin
              fsm_d       = HOLD;
              cnt_d       = '0;
              prn_d       = word_d;
              prn_valid_d = 1'b1;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
          HOLD: begin
            if (prn_ready) begin
              fsm_d       = IDLE;
              prn_valid_d = 1'b0;
            end
          end
          default: begin
            fsm_d       = IDLE;
            prn_valid_d = 1'b0;
          end
        endcase
      end
    end else if (fsm_q == IDLE && !mode) begin
      // Free-run valid tracks the previous cycle's enable.
      prn_valid_d = 1'b0;
    end
  end

  assign prn          = prn_q;
  assign prn_valid    = prn_valid_q;
  assign period_pulse = period_q;
  assign seed_err     = seed_err_q;

endmodule

// File: tb/tb_lfsr_prn_gen.sv
// Directed bench for lfsr_prn_gen: free-run taps, word handshake, seed handling,
// async reset and a 4-bit instance for full-period coverage.
module tb_lfsr_prn_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, mode, seed_load, req, prn_ready;
  logic [9:0] seed_in;
  logic [4:0] prn;
  logic       prn_valid, period_pulse, seed_err;

  logic       mode2, seed_load2, req2, ready2;
  logic [3:0] seed_in2, prn2;
  logic       valid2, pulse2, err2;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  lfsr_prn_gen #(
    .WIDTH(10), .TAPS(10'h300), .OUT_W(5), .STRIDE(2), .SEED(10'h001)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .seed_load(seed_load),
    .seed_in(seed_in), .req(req), .prn_ready(prn_ready), .prn(prn),
    .prn_valid(prn_valid), .period_pulse(period_pulse), .seed_err(seed_err)
  );

  lfsr_prn_gen #(
    .WIDTH(4), .TAPS(4'b1100), .OUT_W(4), .STRIDE(1), .SEED(4'h1)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode2), .seed_load(seed_load2),
    .seed_in(seed_in2), .req(req2), .prn_ready(ready2), .prn(prn2),
    .prn_valid(valid2), .period_pulse(pulse2), .seed_err(err2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned lat, held, zeros, first, second, distinct;
    logic [15:0] seen;

    rst_n = 1'b0; en = 1'b0; mode = 1'b0; seed_load = 1'b0; seed_in = '0;
    req = 1'b0; prn_ready = 1'b0;
    mode2 = 1'b0; seed_load2 = 1'b0; seed_in2 = '0; req2 = 1'b0; ready2 = 1'b0;
    tick();
    check("rst_prn", prn, 0);
    check("rst_valid", prn_valid, 0);
    check("rst_pulse", period_pulse, 0);
    check("rst_err", seed_err, 0);

    // Free-run from SEED: 0x002 -> prn 10000, 0x100 -> 0, 0x201 -> 00001
    en = 1'b1; mode = 1'b0; rst_n = 1'b1;
    tick();
    check("free_c1_prn", prn, 5'b10000);
    check("free_c1_valid", prn_valid, 1);
    repeat (7) tick();
    check("free_c8_prn", prn, 5'b00000);
    tick();
    check("free_c9_prn", prn, 5'b00001);
    en = 1'b0;
    tick();
    check("free_en0_valid", prn_valid, 0);
    check("free_en0_prn", prn, 5'b00001);

    // Word mode from SEED: word of zeros, latency 6, held without ready
    do_reset();
    en = 1'b1; mode = 1'b1; req = 1'b1;
    tick();
    req = 1'b0; lat = 1;
    while (!prn_valid && lat < 40) begin tick(); lat++; end
    check("word_latency", lat, 6);
    check("word_prn", prn, 5'b00000);
    held = 0; req = 1'b1; mode = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (prn_valid === 1'b1 && prn === 5'b00000) held++;
    end
    check("word_hold", held, 10);
    req = 1'b0; mode = 1'b1; prn_ready = 1'b1;
    tick();
    prn_ready = 1'b0;
    check("word_xfer_valid", prn_valid, 0);

    // Seed 0x3A5 (loaded with en=0): word bits 9..5 LSB-first -> 10111
    en = 1'b0; seed_in = 10'h3A5; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; en = 1'b1; req = 1'b1;
    tick();
    req = 1'b0; lat = 1;
    while (!prn_valid && lat < 40) begin tick(); lat++; end
    check("seeded_latency", lat, 6);
    check("seeded_word", prn, 5'b10111);
    prn_ready = 1'b1;
    tick();
    prn_ready = 1'b0;

    // Same word with en toggling during SHIFT: five paused cycles
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0; lat = 1; zeros = 0;
    while (!prn_valid && lat < 40) begin
      en = ~en;
      if (!en) zeros++;
      tick();
      lat++;
    end
    en = 1'b1;
    check("pause_latency", lat, 11);
    check("pause_word", prn, 5'b10111);

    // Asynchronous reset mid-HOLD clears outputs before the next edge
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", prn_valid, 0);
    check("async_rst_prn", prn, 0);
    tick();
    rst_n = 1'b1; mode = 1'b1;
    tick();
    check("post_rst_idle", prn_valid, 0);

    // Zero seed_load during SHIFT: recover to SEED, pulse seed_err, back to IDLE
    seed_in = 10'h3A5; seed_load = 1'b1;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    seed_in = '0; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("zseed_err", seed_err, 1);
    check("zseed_valid", prn_valid, 0);
    tick();
    check("zseed_err_pulse", seed_err, 0);
    held = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (prn_valid !== 1'b0) held++;
    end
    check("zseed_idle", held, 0);
    mode = 1'b0;
    tick();
    check("zseed_state", prn, 5'b10000);

    // Loading SEED explicitly never raises period_pulse
    seed_in = 10'h001; seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    check("load_no_pulse", period_pulse, 0);

    // 4-bit maximal LFSR: pulse every 15 shifts, 15 distinct nonzero states
    do_reset();
    en = 1'b1;
    first = 0; second = 0; distinct = 0; seen = '0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c <= 15 && !seen[prn2]) begin
        seen[prn2] = 1'b1;
        distinct++;
      end
      if (pulse2) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
    end
    check("p4_first_pulse", first, 15);
    check("p4_period", second - first, 15);
    check("p4_distinct", distinct, 15);
    check("p4_no_zero", seen[0], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_prn_gen.md
LFSR_PRN_GEN -- requirements
Module: lfsr_prn_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 10, LFSR state width (range 3..32).
REQ-002 SHALL have parameter TAPS, default 10'h300, feedback mask; feedback = XOR of state bits whose TAPS bit is 1.
REQ-003 SHALL have parameter OUT_W, default 5, output word width; elaboration SHALL fail unless WIDTH >= 1+STRIDE*(OUT_W-1).
REQ-004 SHALL have parameter STRIDE, default 2, stage spacing of free-run output taps.
REQ-005 SHALL have parameter SEED, default 1, reset/recovery state; elaboration SHALL fail if SEED == 0.
REQ-006 clk  input  1  rising-edge clock, sole clock.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 en  input  1  advance enable; low freezes state, FSM and outputs.
REQ-009 mode  input  1  0 = FREE (one shift/cycle), 1 = WORD (serial word generation with handshake).
REQ-010 seed_load  input  1  load seed_in into state this cycle.
REQ-011 seed_in  input  WIDTH  seed value for seed_load.
REQ-012 req  input  1  WORD mode: request one word.
REQ-013 prn_ready  input  1  WORD mode: consumer accepts prn.
REQ-014 prn  output  OUT_W  pseudo-random output.
REQ-015 prn_valid  output  1  prn holds valid data.
REQ-016 period_pulse  output  1  one-cycle pulse when state returns to SEED after a shift.
REQ-017 seed_err  output  1  one-cycle pulse when a zero seed was rejected.

Function
REQ-018 Shift SHALL be state <= {state[WIDTH-2:0], fb}, new bit entering bit 0.
REQ-019 FSM states SHALL be IDLE, SHIFT, HOLD; FSM SHALL advance only when en=1.
REQ-020 FREE mode (FSM in IDLE, mode=0, en=1): state SHALL shift every cycle; prn[k] SHALL equal state[WIDTH-1-STRIDE*k] of the post-shift (registered) state; prn_valid SHALL equal en of the previous cycle.
REQ-021 mode SHALL be sampled only in IDLE; changes during SHIFT/HOLD SHALL be ignored until return to IDLE.
REQ-022 WORD mode: IDLE with req=1, en=1 -> SHIFT; counter cleared, prn_valid=0.
REQ-023 SHIFT: each enabled cycle SHALL capture pre-shift state[WIDTH-1] into word bit k (k = 0..OUT_W-1, LSB first), then shift; after OUT_W shifts -> HOLD.
REQ-024 HOLD: prn SHALL hold the captured word and prn_valid=1 until prn_ready=1; transfer on prn_valid&prn_ready; then -> IDLE (prn_valid=0 next cycle); state SHALL NOT shift in HOLD.
REQ-025 Request-to-valid latency SHALL be OUT_W+1 enabled cycles; req in HOLD or SHIFT SHALL be ignored.
REQ-026 en=0 in SHIFT SHALL pause the shift counter without losing captured bits.
REQ-027 seed_load SHALL take priority over all other activity regardless of en: state <= seed_in, FSM -> IDLE, prn_valid -> 0, word in progress discarded.
REQ-028 seed_load with seed_in == 0 SHALL load SEED instead and pulse seed_err for one cycle.
REQ-029 If state is ever all-zero otherwise, next enabled cycle SHALL load SEED and pulse seed_err.
REQ-030 period_pulse SHALL assert the cycle after a shift produces state == SEED; never on seed_load.

Reset
REQ-031 rst_n low SHALL immediately set state=SEED, FSM=IDLE, counter=0, prn=0, prn_valid=0, period_pulse=0, seed_err=0.
REQ-032 Reset mid-word SHALL discard the word; first cycle after release with en=1 SHALL behave as IDLE.

Verification
REQ-033 Defaults, reset release, mode=0, en=1 -> state 0x002 after 1 cycle, 0x100 after 8, 0x201 after 9; prn=5'b00001 at 0x201.
REQ-034 WIDTH=4, TAPS=4'b1100, SEED=1, FREE -> period_pulse every 15 cycles, all 15 nonzero states visited.
REQ-035 Defaults, WORD, req pulse, prn_ready=0 -> prn_valid rises 6 cycles after req, prn=5'b00000, held 10 cycles; prn_ready=1 -> prn_valid=0 next cycle.
REQ-036 seed_load=1, seed_in=0 during SHIFT -> state=SEED, seed_err one-cycle pulse, FSM IDLE, prn_valid=0.
REQ-037 en toggled 1/0 during SHIFT -> word identical to uninterrupted run, latency extended by count of en=0 cycles.
REQ-038 rst_n asserted asynchronously mid-HOLD -> prn_valid=0 and prn=0 before next clk edge.
